// File: rtl/movement_controller.sv
// Cursor movement sequencer: drives the datapath control code through clear/step/draw passes.
// Optional feature macro: DIAGONAL_EN (one pass issues both a horizontal and a vertical step).
module movement_controller #(
    parameter int unsigned TICK_DIV = 833333,
    parameter int unsigned CNT_W    = 20,
    parameter int unsigned WDOG     = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       draw_done,
    output logic [3:0] control,
    output logic       busy,
    output logic       frame_tick,
    output logic       wdog_err
);

    localparam int unsigned WD_W = $clog2(WDOG + 1);

    typedef enum logic [3:0] {
        StPrehold = 4'b0100,
        StHold    = 4'b0000,
        StClear   = 4'b0001,
        StLeft    = 4'b0011,
        StRight   = 4'b0010,
        StDown    = 4'b0110,
        StUp      = 4'b0111,
        StDraw    = 4'b0101
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [WD_W-1:0]  wdog_cnt_q, wdog_cnt_d;
    logic [3:0]       dir_q, dir_d;  // {up, down, left, right}
    logic             done_q, busy_q, wdog_err_q, wdog_err_d;
    logic             done_rise, h_req, v_req, live_h, live_v, wdog_expired;
    state_e           h_step, v_step;

    assign frame_tick   = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
    assign tick_cnt_d   = frame_tick ? '0 : tick_cnt_q + CNT_W'(1);
    assign done_rise    = draw_done & ~done_q;
    assign h_req        = dir_q[1] ^ dir_q[0];
    assign v_req        = dir_q[3] ^ dir_q[2];
    assign live_h       = btn_left ^ btn_right;
    assign live_v       = btn_up ^ btn_down;
    assign h_step       = dir_q[0] ? StRight : StLeft;
    assign v_step       = dir_q[2] ? StDown : StUp;
    assign wdog_expired = (wdog_cnt_q == WD_W'(WDOG - 1));

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        wdog_err_d = wdog_err_q;
        unique case (state_q)
            StPrehold: state_d = StClear;
            StHold: begin
                if (frame_tick) begin
                    dir_d = {btn_up, btn_down, btn_left, btn_right};
                    if (live_h || live_v) state_d = StClear;
                end
            end
            StClear: begin
                if (done_rise) begin
                    if (h_req)      state_d = h_step;
                    else if (v_req) state_d = v_step;
                    else            state_d = StDraw;
                end else if (wdog_expired) begin
                    state_d    = StHold;
                    wdog_err_d = 1'b1;
                    dir_d      = '0;
                end
            end
            StLeft, StRight: begin
`ifdef DIAGONAL_EN
                state_d = v_req ? v_step : StDraw;
`else
                state_d = StDraw;
`endif
            end
            StUp, StDown: state_d = StDraw;
            StDraw: begin
                if (done_rise) begin
                    state_d = StHold;
                end else if (wdog_expired) begin
                    state_d    = StHold;
                    wdog_err_d = 1'b1;
                    dir_d      = '0;
                end
            end
            default: state_d = StPrehold;
        endcase
    end

    // Watchdog restarts on every state change, so entering CLEAR or DRAW starts from zero.
    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        if (state_d != state_q) begin
            wdog_cnt_d = '0;
        end else if (state_q == StClear || state_q == StDraw) begin
            wdog_cnt_d = wdog_cnt_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StPrehold;
            tick_cnt_q <= '0;
            wdog_cnt_q <= '0;
            dir_q      <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b1;
            wdog_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            wdog_cnt_q <= wdog_cnt_d;
            dir_q      <= dir_d;
            done_q     <= draw_done;
            busy_q     <= (state_d != StHold);
            wdog_err_q <= wdog_err_d;
        end
    end

    assign control  = state_q;
    assign busy     = busy_q;
    assign wdog_err = wdog_err_q;

endmodule

// File: tb/tb_movement_controller.sv
// Self-checking bench for movement_controller with a small datapath model (draw_done, X/Y).
module tb_movement_controller;

    localparam logic [3:0] C_PRE = 4'b0100, C_HOLD = 4'b0000, C_CLR = 4'b0001;
    localparam logic [3:0] C_LEFT = 4'b0011, C_RIGHT = 4'b0010, C_DOWN = 4'b0110;
    localparam logic [3:0] C_UP = 4'b0111, C_DRAW = 4'b0101;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] btns;  // {left, right, up, down}
    logic       draw_done;
    logic [3:0] control;
    logic       busy, frame_tick, wdog_err;

    logic       dd_en;
    logic       dd_q = 1'b0;
    int         dd_cnt = 0;
    logic [3:0] last_ctl = 4'b0100;
    int         x = 0, y = 0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    movement_controller #(.TICK_DIV(8), .CNT_W(4), .WDOG(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_left   (btns[3]),
        .btn_right  (btns[2]),
        .btn_up     (btns[1]),
        .btn_down   (btns[0]),
        .draw_done  (draw_done),
        .control    (control),
        .busy       (busy),
        .frame_tick (frame_tick),
        .wdog_err   (wdog_err)
    );

    assign draw_done = dd_en & dd_q;

    // Datapath model: done rises 4 cycles after entering CLEAR/DRAW and holds until the next entry.
    always @(negedge clk) begin
        if (control != last_ctl && (control == C_CLR || control == C_DRAW)) begin
            dd_cnt <= 1;
            dd_q   <= 1'b0;
        end else if (dd_cnt != 0 && dd_cnt < 4) begin
            dd_cnt <= dd_cnt + 1;
            if (dd_cnt == 3) dd_q <= 1'b1;
        end
        case (control)
            C_PRE:   begin x <= 50; y <= 50; end
            C_RIGHT: x <= x + 1;
            C_LEFT:  x <= x - 1;
            C_DOWN:  y <= y + 1;
            C_UP:    y <= y - 1;
            default: ;
        endcase
        last_ctl <= control;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_code(input logic [3:0] code, input int bound, output bit ok);
        int n;
        n = 0;
        while (control !== code && n < bound) begin
            @(negedge clk);
            n++;
        end
        ok = (control === code);
    endtask

    // Records each distinct control code from now until HOLD, as packed nibbles.
    task automatic collect(output logic [23:0] seq, output int steps);
        logic [3:0] last;
        int n;
        seq   = {20'd0, control};
        last  = control;
        steps = 0;
        n     = 0;
        while (control !== C_HOLD && n < 80) begin
            @(negedge clk);
            n++;
            if (control !== last) begin
                seq  = {seq[19:0], control};
                last = control;
            end
            if (control inside {C_LEFT, C_RIGHT, C_UP, C_DOWN}) steps++;
        end
    endtask

    typedef struct {
        logic [3:0]  btn;
        logic [23:0] seq;
        int          steps;
        int          dx;
        int          dy;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [23:0] seq;
        int          steps, n, x0, y0;
        bit          ok;

        vecs[0] = '{4'b0100, 24'h1250, 1, 1, 0};
        vecs[1] = '{4'b1000, 24'h1350, 1, -1, 0};
        vecs[2] = '{4'b0010, 24'h1750, 1, 0, -1};
        vecs[3] = '{4'b0001, 24'h1650, 1, 0, 1};
`ifdef DIAGONAL_EN
        vecs[4] = '{4'b0101, 24'h12650, 2, 1, 1};
        vecs[5] = '{4'b1010, 24'h13750, 2, -1, -1};
`else
        vecs[4] = '{4'b0101, 24'h1250, 1, 1, 0};
        vecs[5] = '{4'b1010, 24'h1350, 1, -1, 0};
`endif
        vecs[6] = '{4'b1101, 24'h1650, 1, 0, 1};

        btns    = 4'b0000;
        dd_en   = 1'b1;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_control", 32'(control), 32'(C_PRE));
        check("reset_busy", 32'(busy), 32'd1);
        check("reset_tick", 32'(frame_tick), 32'd0);
        check("reset_wdog", 32'(wdog_err), 32'd0);

        reset_n = 1'b1;
        collect(seq, steps);
        check("init_seq", 32'(seq), 32'h4150);
        check("init_busy", 32'(busy), 32'd0);
        check("init_wdog", 32'(wdog_err), 32'd0);
        check("init_x", 32'(x), 32'd50);
        check("init_y", 32'(y), 32'd50);

        n = 0;
        while (!frame_tick && n < 20) begin @(negedge clk); n++; end
        n = 0;
        do begin @(negedge clk); n++; end while (!frame_tick && n < 20);
        check("tick_period", 32'(n), 32'd8);

        for (int i = 0; i < 7; i++) begin
            x0   = x;
            y0   = y;
            btns = vecs[i].btn;
            wait_code(C_CLR, 30, ok);
            check($sformatf("vec%0d_start", i), 32'(ok), 32'd1);
            btns = 4'b0000;
            collect(seq, steps);
            check($sformatf("vec%0d_seq", i), 32'(seq), 32'(vecs[i].seq));
            check($sformatf("vec%0d_steps", i), 32'(steps), 32'(vecs[i].steps));
            check($sformatf("vec%0d_dx", i), 32'(x - x0), 32'(vecs[i].dx));
            check($sformatf("vec%0d_dy", i), 32'(y - y0), 32'(vecs[i].dy));
        end

        // Opposing horizontal buttons cancel: no pass over three ticks.
        x0   = x;
        btns = 4'b1100;
        n    = 0;
        repeat (30) begin
            @(negedge clk);
            if (control !== C_HOLD) n++;
        end
        btns = 4'b0000;
        check("cancel_busy_cycles", 32'(n), 32'd0);
        check("cancel_x", 32'(x), 32'(x0));

        // Watchdog: draw_done never rises in CLEAR.
        dd_en = 1'b0;
        btns  = 4'b0100;
        wait_code(C_CLR, 30, ok);
        check("wdog_start", 32'(ok), 32'd1);
        btns = 4'b0000;
        n    = 0;
        while (control === C_CLR && n < 40) begin n++; @(negedge clk); end
        check("wdog_cycles", 32'(n), 32'd16);
        check("wdog_control", 32'(control), 32'(C_HOLD));
        check("wdog_err_set", 32'(wdog_err), 32'd1);
        dd_en = 1'b1;
        btns  = 4'b0100;
        wait_code(C_CLR, 30, ok);
        btns = 4'b0000;
        collect(seq, steps);
        check("wdog_after_seq", 32'(seq), 32'h1250);
        check("wdog_sticky", 32'(wdog_err), 32'd1);

        // Reset mid-DRAW returns to PREHOLD asynchronously and reruns init.
        btns = 4'b0100;
        wait_code(C_CLR, 30, ok);
        btns = 4'b0000;
        wait_code(C_DRAW, 20, ok);
        check("mid_draw_reached", 32'(ok), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_control", 32'(control), 32'(C_PRE));
        check("async_busy", 32'(busy), 32'd1);
        check("async_wdog_clr", 32'(wdog_err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        collect(seq, steps);
        check("reinit_seq", 32'(seq), 32'h4150);
        check("reinit_x", 32'(x), 32'd50);
        check("reinit_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
